// File: rtl/decode_scan.sv
// decode_scan: registered one-hot decoder with an auto-scan mode.
//   mode=0 : out/idx follow sel one cycle after sampling.
//   mode=1 : idx steps 0..OUT_W-1 and holds each position dwell+1 cycles;
//            load jumps to sel; wrap pulses when idx rolls OUT_W-1 -> 0.
// Optional build macro: DECODE_SCAN_BLANK_EN adds a 'blank' input that
// forces out to all-zero while idx/cnt/wrap keep running.
module decode_scan #(
    parameter int SEL_W   = 2,
    parameter int OUT_W   = 2 ** SEL_W,
    parameter int DWELL_W = 4
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               en,
    input  logic               mode,
    input  logic [SEL_W-1:0]   sel,
    input  logic               load,
    input  logic [DWELL_W-1:0] dwell,
`ifdef DECODE_SCAN_BLANK_EN
    input  logic               blank,
`endif
    output logic [OUT_W-1:0]   out,
    output logic [SEL_W-1:0]   idx,
    output logic               wrap
);

    localparam logic [SEL_W-1:0] IDX_LAST = SEL_W'(OUT_W - 1);

    logic [SEL_W-1:0]   idx_q, idx_d;
    logic [DWELL_W-1:0] cnt_q, cnt_d;
    logic [OUT_W-1:0]   out_q, out_d;
    logic               wrap_q, wrap_d;
    logic               blank_s;

`ifdef DECODE_SCAN_BLANK_EN
    assign blank_s = blank;
`else
    assign blank_s = 1'b0;
`endif

    // Next-state: direct decode, load, dwell count and advance; out tracks idx_d
    always_comb begin
        idx_d  = idx_q;
        cnt_d  = cnt_q;
        out_d  = out_q;
        wrap_d = 1'b0;
        if (en) begin
            if (!mode || load) begin
                // load only reaches here in scan mode; in direct mode it is moot
                idx_d = sel;
                cnt_d = '0;
            end else if (cnt_q >= dwell) begin
                // >= so a dwell lowered below cnt advances at once and cnt never rolls over
                idx_d  = SEL_W'(idx_q + 1'b1);
                cnt_d  = '0;
                wrap_d = (idx_q == IDX_LAST);
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            out_d = '0;
            if (!blank_s) begin
                out_d[idx_d] = 1'b1;
            end
        end
    end

    // State register with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            idx_q  <= '0;
            cnt_q  <= '0;
            out_q  <= OUT_W'(1);
            wrap_q <= 1'b0;
        end else begin
            idx_q  <= idx_d;
            cnt_q  <= cnt_d;
            out_q  <= out_d;
            wrap_q <= wrap_d;
        end
    end

    assign out  = out_q;
    assign idx  = idx_q;
    assign wrap = wrap_q;

endmodule
